// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package if_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RSP  = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned DEFAULT_PC_STEP = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_sumado;
  } entry_t;

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// Circular-buffer FIFO with synchronous clear; head entry reads as zero when empty.
module prefetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    if (do_pop) head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks the read data to zero.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !clear_i && push_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = (count_q != '0) ? mem_q[head_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: one-outstanding fetch FSM feeding a prefetch queue to ID.
module if_prefetch_queue
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   id_ready,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instruction_ID,
  output logic [ADDR_W-1:0]      PC_sumado_ID,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam int unsigned       EW   = DATA_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              issue, push, pop;
  logic [EW-1:0]     head_entry;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    issue      = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        issue = rst_n && (occupancy < ($clog2(DEPTH)+1)'(DEPTH)) && !redirect_valid;
        if (issue && imem_ready) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + STEP;
          state_d    = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // A response coinciding with a redirect is dropped here rather than via WAIT_DROP.
        if (imem_rvalid) begin
          push    = !redirect_valid;
          state_d = IDLE;
        end else if (redirect_valid) begin
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign pop = instr_valid && id_ready && !redirect_valid;

  prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({imem_rdata, req_pc_q + STEP}),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (occupancy)
  );

  assign imem_req       = issue;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = (occupancy != '0);
  assign instruction_ID = head_entry[EW-1:ADDR_W];
  assign PC_sumado_ID   = head_entry[ADDR_W-1:0];

endmodule
